// File: rtl/input_pkg.sv
// Shared definitions for the input conditioner.
//   - JB_*  : bit positions inside a 16-bit hps_io joystick word
//   - F_*   : bit positions inside the 6-bit player field {trig2, trig1, left, down, right, up}
//   - SC_*  : PS/2 set-2 scancodes that drive buttons
//   - coin_state_t : coin pulse shaper states
//   - joy_to_field : reorders joystick bits [5:0] into player field order
package input_pkg;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_TRIG1  = 4;
    localparam int JB_TRIG2  = 5;
    localparam int JB_START1 = 6;
    localparam int JB_START2 = 7;
    localparam int JB_COIN   = 8;

    localparam int F_UP    = 0;
    localparam int F_RIGHT = 1;
    localparam int F_DOWN  = 2;
    localparam int F_LEFT  = 3;
    localparam int F_TRIG1 = 4;
    localparam int F_TRIG2 = 5;

    // Player 1 arrows arrive as extended codes, but the extended bit is ignored for them.
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_TRIG1 = 8'h29;
    localparam logic [7:0] SC_P1_TRIG2 = 8'h14;
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_TRIG1 = 8'h1C;
    localparam logic [7:0] SC_P2_TRIG2 = 8'h1B;
    localparam logic [7:0] SC_F1       = 8'h05;
    localparam logic [7:0] SC_F2       = 8'h06;
    localparam logic [7:0] SC_START1   = 8'h16;
    localparam logic [7:0] SC_START2   = 8'h1E;
    localparam logic [7:0] SC_COIN1    = 8'h2E;
    localparam logic [7:0] SC_COIN2    = 8'h36;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    function automatic logic [5:0] joy_to_field(input logic [5:0] j);
        logic [5:0] f;
        f          = '0;
        f[F_UP]    = j[JB_UP];
        f[F_RIGHT] = j[JB_RIGHT];
        f[F_DOWN]  = j[JB_DOWN];
        f[F_LEFT]  = j[JB_LEFT];
        f[F_TRIG1] = j[JB_TRIG1];
        f[F_TRIG2] = j[JB_TRIG2];
        return f;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle between hps_io (keyboard/joysticks) and the game core input ports.
//   master : drives ps2_key, joystk1, joystk2, cabinet; receives inp0/1/2, coin_busy
//   slave  : the input conditioner itself
interface input_conditioner_if;
    logic [10:0] ps2_key;
    logic [15:0] joystk1;
    logic [15:0] joystk2;
    logic        cabinet;
    logic [5:0]  inp0;
    logic [5:0]  inp1;
    logic [2:0]  inp2;
    logic        coin_busy;

    modport master (
        output ps2_key, joystk1, joystk2, cabinet,
        input  inp0, inp1, inp2, coin_busy
    );

    modport slave (
        input  ps2_key, joystk1, joystk2, cabinet,
        output inp0, inp1, inp2, coin_busy
    );
endinterface

// File: rtl/coin_shaper.sv
// Turns coin requests into fixed-width pulses separated by a minimum gap.
// Rising edges of raw_coin are queued (saturating at COIN_QMAX).
//   clk_sys, reset_n : clock, async active-low reset
//   raw_coin         : OR of every coin source
//   coin             : high exactly while a pulse is being emitted
//   busy             : pulse/gap in progress or requests pending (one cycle late,
//                      so the IDLE dispatch cycle is covered)
//
// state | meaning
// IDLE  | no pulse; dispatches the next queued request
// PULSE | coin high, counting COIN_PULSE cycles
// GAP   | coin low, counting COIN_GAP cycles before the next dispatch
module coin_shaper
    import input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 4800000,
    parameter int unsigned COIN_GAP   = 4800000,
    parameter int unsigned COIN_QMAX  = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_coin,
    output logic coin,
    output logic busy
);
    localparam int unsigned CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int          CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int          QW   = (COIN_QMAX > 0) ? $clog2(COIN_QMAX + 1) : 1;

    coin_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] pend_q, pend_d;
    logic          rc_q, coin_q, busy_q;
    logic          rise, dispatch;

    assign rise     = raw_coin & ~rc_q;
    assign dispatch = (state_q == IDLE) && (pend_q != '0);

    // Simultaneous enqueue and dispatch cancel out.
    always_comb begin
        pend_d = pend_q;
        if (rise && !dispatch) begin
            if (pend_q != QW'(COIN_QMAX))
                pend_d = pend_q + QW'(1);
        end else if (dispatch && !rise) begin
            pend_d = pend_q - QW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            rc_q    <= 1'b0;
            coin_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rc_q   <= raw_coin;
            pend_q <= pend_d;
            busy_q <= (state_q != IDLE) || (pend_q != '0);
            unique case (state_q)
                IDLE: begin
                    if (dispatch) begin
                        state_q <= PULSE;
                        cnt_q   <= CW'(COIN_PULSE - 1);
                        coin_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= GAP;
                        cnt_q   <= CW'(COIN_GAP - 1);
                        coin_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q - CW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    coin_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin = coin_q;
    assign busy = busy_q;
endmodule

// File: rtl/input_conditioner.sv
// Input stage for the game core: decodes PS/2 key events into held buttons,
// merges them with both joysticks (player 2 mirrors onto player 1 on an
// upright cabinet) and shapes coin requests.
//   clk_sys, reset_n : clock, async active-low reset
//   bus (slave)      : ps2_key, joystk1, joystk2, cabinet in;
//                      inp0 (player 1), inp1 (player 2), inp2 {coin, start2, start1},
//                      coin_busy out -- all outputs registered
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 4800000,
    parameter int unsigned COIN_GAP   = 4800000,
    parameter int unsigned COIN_QMAX  = 3
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input_conditioner_if.slave bus
);
    logic       primed_q, tog_q;
    logic [5:0] key_p1_q, key_p1_d, key_p2_q, key_p2_d;
    logic       key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic       key_c1_q, key_c1_d, key_c2_q, key_c2_d;
    logic [5:0] inp0_q, inp0_d, inp1_q, inp1_d;
    logic [2:0] inp2_q, inp2_d;
    logic       coin_busy_q;
    logic [5:0] p2_mrg;
    logic [7:0] code;
    logic       pressed, ext, evt;
    logic       raw_coin, coin, shaper_busy;
    logic       unused_joy_hi;

    assign code    = bus.ps2_key[7:0];
    assign pressed = bus.ps2_key[9];
    assign ext     = bus.ps2_key[8];
    // The first edge after reset only captures the toggle level.
    assign evt     = primed_q && (bus.ps2_key[10] != tog_q);

    assign unused_joy_hi = ^{bus.joystk1[15:9], bus.joystk2[15:9]};

    always_comb begin
        key_p1_d = key_p1_q;
        key_p2_d = key_p2_q;
        key_s1_d = key_s1_q;
        key_s2_d = key_s2_q;
        key_c1_d = key_c1_q;
        key_c2_d = key_c2_q;
        if (evt) begin
            case (code)
                SC_P1_UP:    key_p1_d[F_UP]    = pressed;
                SC_P1_DOWN:  key_p1_d[F_DOWN]  = pressed;
                SC_P1_LEFT:  key_p1_d[F_LEFT]  = pressed;
                SC_P1_RIGHT: key_p1_d[F_RIGHT] = pressed;
                default: ;
            endcase
            if (!ext) begin
                case (code)
                    SC_P1_TRIG1: key_p1_d[F_TRIG1] = pressed;
                    SC_P1_TRIG2: key_p1_d[F_TRIG2] = pressed;
                    SC_P2_UP:    key_p2_d[F_UP]    = pressed;
                    SC_P2_DOWN:  key_p2_d[F_DOWN]  = pressed;
                    SC_P2_LEFT:  key_p2_d[F_LEFT]  = pressed;
                    SC_P2_RIGHT: key_p2_d[F_RIGHT] = pressed;
                    SC_P2_TRIG1: key_p2_d[F_TRIG1] = pressed;
                    SC_P2_TRIG2: key_p2_d[F_TRIG2] = pressed;
                    SC_F1: begin
                        key_s1_d = pressed;
                        key_c1_d = pressed;
                    end
                    SC_F2: begin
                        key_s2_d = pressed;
                        key_c2_d = pressed;
                    end
                    SC_START1:   key_s1_d = pressed;
                    SC_START2:   key_s2_d = pressed;
                    SC_COIN1:    key_c1_d = pressed;
                    SC_COIN2:    key_c2_d = pressed;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        p2_mrg = key_p2_q | joy_to_field(bus.joystk2[5:0]);
        inp1_d = p2_mrg;
        inp0_d = key_p1_q | joy_to_field(bus.joystk1[5:0]) | (bus.cabinet ? 6'd0 : p2_mrg);
        inp2_d = {coin,
                  key_s2_q | bus.joystk1[JB_START2] | bus.joystk2[JB_START2],
                  key_s1_q | bus.joystk1[JB_START1] | bus.joystk2[JB_START1]};
    end

    assign raw_coin = key_c1_q | key_c2_q | bus.joystk1[JB_COIN] | bus.joystk2[JB_COIN];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed_q    <= 1'b0;
            tog_q       <= 1'b0;
            key_p1_q    <= '0;
            key_p2_q    <= '0;
            key_s1_q    <= 1'b0;
            key_s2_q    <= 1'b0;
            key_c1_q    <= 1'b0;
            key_c2_q    <= 1'b0;
            inp0_q      <= '0;
            inp1_q      <= '0;
            inp2_q      <= '0;
            coin_busy_q <= 1'b0;
        end else begin
            primed_q    <= 1'b1;
            // Either the priming capture or the event update; equal otherwise.
            tog_q       <= bus.ps2_key[10];
            key_p1_q    <= key_p1_d;
            key_p2_q    <= key_p2_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_c1_q    <= key_c1_d;
            key_c2_q    <= key_c2_d;
            inp0_q      <= inp0_d;
            inp1_q      <= inp1_d;
            inp2_q      <= inp2_d;
            coin_busy_q <= shaper_busy;
        end
    end

    coin_shaper #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .COIN_QMAX  (COIN_QMAX)
    ) u_coin_shaper (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .raw_coin (raw_coin),
        .coin     (coin),
        .busy     (shaper_busy)
    );

    assign bus.inp0      = inp0_q;
    assign bus.inp1      = inp1_q;
    assign bus.inp2      = inp2_q;
    assign bus.coin_busy = coin_busy_q;
endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    localparam int P  = 8;
    localparam int G  = 4;
    localparam int QM = 3;

    typedef struct packed {
        logic [7:0] code;
        logic       arrow;
        logic [1:0] grp;   // 0 player1, 1 player2, 2 misc {c2,c1,s2,s1}
        logic [2:0] idx;
    } kent_t;

    kent_t ktab [20] = '{
        '{8'h75, 1'b1, 2'd0, 3'd0}, '{8'h72, 1'b1, 2'd0, 3'd2},
        '{8'h6B, 1'b1, 2'd0, 3'd3}, '{8'h74, 1'b1, 2'd0, 3'd1},
        '{8'h29, 1'b0, 2'd0, 3'd4}, '{8'h14, 1'b0, 2'd0, 3'd5},
        '{8'h2D, 1'b0, 2'd1, 3'd0}, '{8'h2B, 1'b0, 2'd1, 3'd2},
        '{8'h23, 1'b0, 2'd1, 3'd3}, '{8'h34, 1'b0, 2'd1, 3'd1},
        '{8'h1C, 1'b0, 2'd1, 3'd4}, '{8'h1B, 1'b0, 2'd1, 3'd5},
        '{8'h05, 1'b0, 2'd2, 3'd0}, '{8'h05, 1'b0, 2'd2, 3'd2},
        '{8'h06, 1'b0, 2'd2, 3'd1}, '{8'h06, 1'b0, 2'd2, 3'd3},
        '{8'h16, 1'b0, 2'd2, 3'd0}, '{8'h1E, 1'b0, 2'd2, 3'd1},
        '{8'h2E, 1'b0, 2'd2, 3'd2}, '{8'h36, 1'b0, 2'd2, 3'd3}
    };

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    input_conditioner_if bus ();

    input_conditioner #(.COIN_PULSE(P), .COIN_GAP(G), .COIN_QMAX(QM)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] mk1, mk2;
    logic [3:0] mmisc;
    logic       mprimed, mtog, rc_m, b1, b2;
    int         e, pend, free_at, last_d;
    bit         have_d;
    logic [5:0] ex0, ex1;
    logic [2:0] ex2;
    logic       exb;

    function automatic logic [5:0] fmap(input logic [15:0] j);
        return {j[5], j[4], j[1], j[2], j[0], j[3]};
    endfunction

    task automatic apply_key(input logic [7:0] code, input logic ext, input logic pr);
        for (int i = 0; i < 20; i++) begin
            if (ktab[i].code == code && (ktab[i].arrow || !ext)) begin
                case (ktab[i].grp)
                    2'd0:    mk1[ktab[i].idx] = pr;
                    2'd1:    mk2[ktab[i].idx] = pr;
                    default: mmisc[ktab[i].idx[1:0]] = pr;
                endcase
            end
        end
    endtask

    always @(posedge clk_sys) begin : model
        logic [5:0]  p1, p2;
        logic [15:0] j1, j2;
        logic [10:0] k;
        logic        raw, rise, disp, coin_now, nonidle;
        j1 = bus.joystk1;
        j2 = bus.joystk2;
        k  = bus.ps2_key;
        if (!reset_n) begin
            mk1 = '0; mk2 = '0; mmisc = '0; mprimed = 0; mtog = 0; rc_m = 0;
            b1 = 0; b2 = 0; e = 0; pend = 0; free_at = 0; last_d = 0; have_d = 0;
            ex0 = '0; ex1 = '0; ex2 = '0; exb = 0;
        end else begin
            p2  = mk2 | fmap(j2);
            p1  = mk1 | fmap(j1) | (bus.cabinet ? 6'd0 : p2);
            raw = mmisc[2] | mmisc[3] | j1[8] | j2[8];
            rise = raw && !rc_m;
            rc_m = raw;
            // A queued request may start once the previous pulse, gap and idle slot are over.
            disp = (e >= free_at) && (pend > 0);
            if (disp) begin
                last_d = e; have_d = 1; free_at = e + P + G + 1;
            end
            if (rise && !disp) pend = (pend < QM) ? pend + 1 : pend;
            else if (disp && !rise) pend = pend - 1;
            coin_now = have_d && (e >= last_d + 1) && (e <= last_d + P);
            nonidle  = have_d && (e >= last_d) && (e <= last_d + P + G - 1);
            exb = b2;
            b2  = b1;
            b1  = nonidle || (pend > 0);
            ex0 = p1;
            ex1 = p2;
            ex2 = {coin_now, mmisc[1] | j1[7] | j2[7], mmisc[0] | j1[6] | j2[6]};
            if (!mprimed) begin
                mprimed = 1; mtog = k[10];
            end else if (k[10] != mtog) begin
                mtog = k[10];
                apply_key(k[7:0], k[8], k[9]);
            end
            e++;
        end
        #1;
        check("m_inp0", bus.inp0, ex0);
        check("m_inp1", bus.inp1, ex1);
        check("m_inp2", bus.inp2, ex2);
        check("m_busy", bus.coin_busy, exb);
    end

    // ---------------- edge monitor ----------------
    int   cyc = 0;
    int   rises[$];
    int   last_fall = 0, last_bfall = 0;
    logic prev_c = 0, prev_b = 0;

    always @(posedge clk_sys) begin
        cyc++;
        #1;
        if (bus.inp2[2] && !prev_c) rises.push_back(cyc);
        if (!bus.inp2[2] && prev_c) last_fall = cyc;
        if (!bus.coin_busy && prev_b) last_bfall = cyc;
        prev_c = bus.inp2[2];
        prev_b = bus.coin_busy;
    end

    // ---------------- stimulus ----------------
    logic tog;

    task automatic send_key(input logic pr, input logic ext, input logic [7:0] code);
        @(negedge clk_sys);
        tog = ~tog;
        bus.ps2_key = {tog, pr, ext, code};
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    initial begin
        int k0;
        tog = 1'b1;
        bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        bus.joystk1 = '0;
        bus.joystk2 = '0;
        bus.cabinet = 1'b1;
        step(3);
        check("rst_inp0", bus.inp0, 6'h00);
        check("rst_busy", bus.coin_busy, 1'b0);
        @(negedge clk_sys) reset_n = 1'b1;
        step(4);
        check("prime_inp0", bus.inp0, 6'h00);
        check("prime_inp1", bus.inp1, 6'h00);
        check("prime_inp2", bus.inp2, 3'b000);

        send_key(1'b1, 1'b1, 8'h75);
        step(1); check("up_lat1", bus.inp0, 6'h00);
        step(1); check("up_set", bus.inp0, 6'h01);
        send_key(1'b0, 1'b1, 8'h75);
        step(1); check("up_hold", bus.inp0, 6'h01);
        step(1); check("up_clr", bus.inp0, 6'h00);
        send_key(1'b1, 1'b0, 8'h14);
        step(2); check("t2_set", bus.inp0, 6'h20);
        send_key(1'b0, 1'b1, 8'h14);
        step(2); check("t2_ext_ignored", bus.inp0, 6'h20);
        send_key(1'b0, 1'b0, 8'h14);
        step(2); check("t2_clr", bus.inp0, 6'h00);
        send_key(1'b1, 1'b0, 8'h1C);
        step(2); check("p2t1_inp1", bus.inp1, 6'h10);
        check("p2t1_inp0", bus.inp0, 6'h00);
        send_key(1'b0, 1'b0, 8'h1C);
        step(2);

        @(negedge clk_sys);
        bus.cabinet = 1'b0;
        bus.joystk2 = 16'h0048;
        step(1);
        check("mir_inp0", bus.inp0, 6'h01);
        check("mir_inp1", bus.inp1, 6'h01);
        check("mir_start", bus.inp2, 3'b001);
        @(negedge clk_sys) bus.cabinet = 1'b1;
        step(1);
        check("nomir_inp0", bus.inp0, 6'h00);
        check("nomir_inp1", bus.inp1, 6'h01);
        @(negedge clk_sys) bus.joystk2 = '0;
        step(2);

        // single coin, held 50 cycles
        rises.delete();
        @(negedge clk_sys) bus.joystk1 = 16'h0100;
        step(1);
        k0 = cyc;
        step(49);
        @(negedge clk_sys) bus.joystk1 = '0;
        step(20);
        check("c1_count", rises.size(), 1);
        if (rises.size() > 0) begin
            check("c1_start", rises[0] - k0, 2);
            check("c1_width", last_fall - rises[0], P);
        end
        check("c1_busy_tail", last_bfall - last_fall, G + 1);

        // five rises two cycles apart: first dispatches at once, the other four saturate the queue
        rises.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys) bus.joystk1 = 16'h0100;
            @(negedge clk_sys) bus.joystk1 = '0;
        end
        step(80);
        check("q_count", rises.size(), 1 + QM);
        for (int i = 1; i < rises.size(); i++)
            check("q_spacing", rises[i] - rises[i-1], P + G + 1);
        check("q_busy_idle", bus.coin_busy, 1'b0);

        // async reset in the middle of a pulse
        rises.delete();
        @(negedge clk_sys) bus.joystk1 = 16'h0100;
        step(4);
        check("ar_high", bus.inp2[2], 1'b1);
        check("ar_busy_high", bus.coin_busy, 1'b1);
        #1;
        reset_n = 1'b0;
        bus.joystk1 = '0;
        #1;
        check("ar_coin_low", bus.inp2[2], 1'b0);
        check("ar_busy_low", bus.coin_busy, 1'b0);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys) reset_n = 1'b1;
        step(30);
        check("ar_no_resume", rises.size(), 1);
        check("ar_inp2", bus.inp2, 3'b000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
